// File: rtl/vector_result_fifo.sv
// Result FIFO between the vectorial ALU and vector register-file write-back.
// Drops results from no-op selects; flush squashes everything stored.
module vector_result_fifo #(
  parameter int N     = 128,
  parameter int DEPTH = 4,
  parameter int RW    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_data,
  input  logic [2:0]                 in_sel,
  input  logic [RW-1:0]              in_rd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_data,
  output logic [2:0]                 out_sel,
  output logic [RW-1:0]              out_rd,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [N-1:0]  d;
    logic [2:0]    s;
    logic [RW-1:0] r;
  } ent_t;

  ent_t          mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic full, keep, push, pop;
  ent_t head;

  assign full     = (cnt_q == CW'(DEPTH));
  assign in_ready = rst & ~full;

  always_comb begin
    keep = 1'b0;
    unique case (in_sel)
      3'd1, 3'd2, 3'd3, 3'd4, 3'd5: keep = 1'b1;
      default:                      keep = 1'b0;
    endcase
  end

  // Zero-select results complete the handshake but never occupy a slot
  assign push = in_valid & in_ready & keep;
  assign pop  = out_valid & out_ready;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wp_d = wp_q + AW'(1);
      if (pop)  rp_d = rp_q + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push && !flush) begin
      mem_q[wp_q] <= '{d: in_data, s: in_sel, r: in_rd};
    end
  end

  assign head      = mem_q[rp_q];
  assign out_valid = (cnt_q != '0);
  assign out_data  = out_valid ? head.d : '0;
  assign out_sel   = out_valid ? head.s : '0;
  assign out_rd    = out_valid ? head.r : '0;
  assign count     = cnt_q;

endmodule

// File: tb/tb_vector_result_fifo.sv
// Directed vector bench for vector_result_fifo.
// Each vector: inputs for one cycle plus the outputs expected in that cycle.
module tb_vector_result_fifo;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [2:0]   in_sel;
  logic [3:0]   in_rd;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [2:0]   out_sel;
  logic [3:0]   out_rd;
  logic         flush;
  logic [2:0]   count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vector_result_fifo #(.N(128), .DEPTH(4), .RW(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .out_rd(out_rd),
    .flush(flush), .count(count)
  );

  typedef struct {
    logic         rst;
    logic         iv;
    logic [2:0]   sel;
    logic [127:0] d;
    logic [3:0]   rd;
    logic         ordy;
    logic         fl;
    logic         e_ir;
    logic         e_ov;
    logic [2:0]   e_sel;
    logic [3:0]   e_rd;
    logic [127:0] e_d;
    logic [2:0]   e_cnt;
  } vec_t;

  localparam logic [127:0] D0 = 128'h0102030405060708090a0b0c0d0e0f10;

  function automatic logic [127:0] pat(input int k);
    logic [7:0] b;
    b = 8'(k) ^ 8'hA5;
    return {16{b}};
  endfunction

  function automatic vec_t mk(
    input logic r, input logic iv, input logic [2:0] s,
    input logic [127:0] d, input logic [3:0] rd,
    input logic ordy, input logic fl,
    input logic eir, input logic eov, input logic [2:0] es,
    input logic [3:0] erd, input logic [127:0] ed, input logic [2:0] ec);
    vec_t v;
    v.rst = r; v.iv = iv; v.sel = s; v.d = d; v.rd = rd;
    v.ordy = ordy; v.fl = fl;
    v.e_ir = eir; v.e_ov = eov; v.e_sel = es;
    v.e_rd = erd; v.e_d = ed; v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst = v.rst; in_valid = v.iv; in_sel = v.sel; in_data = v.d;
    in_rd = v.rd; out_ready = v.ordy; flush = v.fl;
    #1;
    chk("in_ready", idx, 128'(in_ready), 128'(v.e_ir));
    chk("out_valid", idx, 128'(out_valid), 128'(v.e_ov));
    chk("out_sel", idx, 128'(out_sel), 128'(v.e_sel));
    chk("out_rd", idx, 128'(out_rd), 128'(v.e_rd));
    chk("out_data", idx, out_data, v.e_d);
    chk("count", idx, 128'(count), 128'(v.e_cnt));
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0;
    in_rd = '0; out_ready = 1'b0; flush = 1'b0;

    // reset + single push/pop
    tbl.push_back(mk(0,0,0,0,0, 0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,1,2,D0,3, 0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0, 1,0, 1,1,2,3,D0,1));
    tbl.push_back(mk(1,0,0,0,0, 0,0, 1,0,0,0,0,0));
    // no-op selects dropped, then sel=001 stored
    tbl.push_back(mk(1,1,0,pat(90),7, 0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,1,6,pat(91),7, 0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,1,7,pat(92),7, 0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,1,1,pat(93),5, 0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0, 0,0, 1,1,1,5,pat(93),1));
    tbl.push_back(mk(1,0,0,0,0, 1,0, 1,1,1,5,pat(93),1));
    tbl.push_back(mk(1,0,0,0,0, 0,0, 1,0,0,0,0,0));
    // fill to full, 5th rejected, drain in order
    tbl.push_back(mk(1,1,3,pat(20),0, 0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,1,3,pat(21),1, 0,0, 1,1,3,0,pat(20),1));
    tbl.push_back(mk(1,1,3,pat(22),2, 0,0, 1,1,3,0,pat(20),2));
    tbl.push_back(mk(1,1,3,pat(23),3, 0,0, 1,1,3,0,pat(20),3));
    tbl.push_back(mk(1,1,3,pat(29),9, 0,0, 0,1,3,0,pat(20),4));
    tbl.push_back(mk(1,0,0,0,0, 1,0, 0,1,3,0,pat(20),4));
    tbl.push_back(mk(1,0,0,0,0, 1,0, 1,1,3,1,pat(21),3));
    tbl.push_back(mk(1,0,0,0,0, 1,0, 1,1,3,2,pat(22),2));
    tbl.push_back(mk(1,0,0,0,0, 1,0, 1,1,3,3,pat(23),1));
    tbl.push_back(mk(1,0,0,0,0, 0,0, 1,0,0,0,0,0));

    foreach (tbl[i]) apply(tbl[i], i);

    // simultaneous push/pop at count=2 across pointer wrap
    apply(mk(1,1,4,pat(0),0, 0,0, 1,0,0,0,0,0), 100);
    apply(mk(1,1,4,pat(1),1, 0,0, 1,1,4,0,pat(0),1), 101);
    for (int k = 2; k < 12; k++) begin
      apply(mk(1,1,4,pat(k),4'(k), 1,0,
               1,1,4,4'(k-2),pat(k-2),2), 100 + k);
    end
    apply(mk(1,0,0,0,0, 1,0, 1,1,4,10,pat(10),2), 112);
    apply(mk(1,0,0,0,0, 1,0, 1,1,4,11,pat(11),1), 113);
    apply(mk(1,0,0,0,0, 0,0, 1,0,0,0,0,0), 114);

    // flush overrides push and pop
    apply(mk(1,1,2,pat(40),1, 0,0, 1,0,0,0,0,0), 200);
    apply(mk(1,1,2,pat(41),2, 0,0, 1,1,2,1,pat(40),1), 201);
    apply(mk(1,1,2,pat(42),3, 0,0, 1,1,2,1,pat(40),2), 202);
    apply(mk(1,1,2,pat(43),4, 1,1, 1,1,2,1,pat(40),3), 203);
    apply(mk(1,0,0,0,0, 0,0, 1,0,0,0,0,0), 204);
    apply(mk(1,0,0,0,0, 0,0, 1,0,0,0,0,0), 205);

    // reset mid-operation
    apply(mk(1,1,5,pat(50),6, 0,0, 1,0,0,0,0,0), 300);
    apply(mk(1,1,5,pat(51),7, 0,0, 1,1,5,6,pat(50),1), 301);
    apply(mk(0,1,5,pat(52),8, 0,0, 0,1,5,6,pat(50),2), 302);
    apply(mk(1,0,0,0,0, 0,0, 1,0,0,0,0,0), 303);
    apply(mk(1,1,1,pat(53),9, 0,0, 1,0,0,0,0,0), 304);
    apply(mk(1,0,0,0,0, 1,0, 1,1,1,9,pat(53),1), 305);
    apply(mk(1,0,0,0,0, 0,0, 1,0,0,0,0,0), 306);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_result_fifo.md
# vector_result_fifo

- Buffers 128-bit results from the vectorial ALU, with each result's destination register index and operation select, until the write-back port accepts them.
- Sits directly downstream of the vectorial ALU, between execute and vector register-file write-back.
- Decouples ALU issue from write-back stalls with a valid/ready handshake on both sides.
- Silently discards results from no-op selects, so write-back only sees real work.

## Interface
Parameters:
- N, 128, vector width in bits (matches ALU datapath)
- DEPTH, 4, number of entries; power of two, minimum 2
- RW, 4, destination register index width

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-low
- in_valid  input  1  ALU result presented this cycle
- in_ready  output  1  block can accept a handshake this cycle
- in_data  input  N  ALU result C
- in_sel  input  3  ALU select that produced in_data
- in_rd  input  RW  destination vector register
- out_valid  output  1  head entry available
- out_ready  input  1  write-back consumes head this cycle
- out_data  output  N  head result
- out_sel  output  3  head select
- out_rd  output  RW  head destination register
- flush  input  1  discard all stored entries (pipeline squash)
- count  output  $clog2(DEPTH+1)  number of valid stored entries

## Operation
- Circular buffer: write pointer wp, read pointer rp (log2(DEPTH) bits each, wrap modulo DEPTH) and count.
- full = (count == DEPTH); empty = (count == 0).
- in_ready = rst & !full. in_ready stays low when full, even if a pop occurs the same cycle.
- Accept = in_valid & in_ready.
  - On accept with in_sel in {001,010,011,100,101}: store {in_data, in_sel, in_rd} at wp, advance wp.
  - On accept with in_sel in {000,110,111} (ALU zero outputs): handshake completes, nothing stored, wp and count unchanged.
- out_valid = !empty; out_data/out_sel/out_rd = entry at rp. All three are zero when empty.
- Pop = out_valid & out_ready; advances rp.
- Same-cycle push (stored) and pop when 0 < count < DEPTH: count unchanged, both pointers advance.
- flush = 1: next cycle wp = rp = count = 0.
  - Overrides any push or pop that same cycle; in_ready is unaffected that cycle.
  - Storage contents need not be cleared.
- Reset (rst == 0 at a clock edge), from any state including mid-operation:
  - wp = rp = count = 0, out_valid = 0, outputs zero.
  - in_ready = 0 while rst is low, 1 in the first cycle after release.
- Data is stored bit-exact; no arithmetic and no lane interpretation.

## Timing
- Write latency: entry accepted at edge k is visible on out_* with out_valid = 1 from edge k onward, i.e. in cycle k+1. There is no combinational in-to-out path.
- out_* depend only on registered state (rp, count, storage).
- in_ready depends on registered count and on rst, not on out_ready.
- Sustained throughput is 1 entry/cycle while 0 < count < DEPTH and both sides are ready.
- When full, at least 1 bubble cycle on the input side per pop.
- count updates at the same edge as the pointers.
- Priority at a clock edge: rst low > flush > push/pop.

## Test plan
- Reset, then push sel=010, data=0x0102…10, rd=3 in cycle 1 -> cycle 2 shows out_valid=1, out_data=0x0102…10, out_sel=010, out_rd=3, count=1. Pop in cycle 2 -> count=0 and out_valid=0 in cycle 3.
- With out_ready=0, push 4 entries rd=0..3 (sel=011) -> count=4, in_ready=0. A 5th in_valid is not accepted. Then out_ready=1 for 4 cycles -> rd 0,1,2,3 delivered in order; after the first pop, in_ready=1.
- Push sel=000, then 110, then 111 with in_valid=1 -> in_ready=1 each cycle, count stays 0, out_valid stays 0. Then push sel=001 -> count=1.
- Hold count=2, push (sel=100) and pop in the same cycle, 10 cycles -> count stays 2, FIFO order preserved across pointer wrap (entries 0..11 exit in order).
- Count=3, assert flush together with in_valid=1 (sel=010) and out_ready=1 -> next cycle count=0, out_valid=0, out_data=0, new data not stored.
- Count=2, drive rst=0 for one cycle with in_valid=1 -> in_ready=0 during reset. After release: count=0, out_valid=0, in_ready=1.
